// File: rtl/ifu_inst_align.sv
// Instruction aligner between the fetch FIFO and decode: splits 32-bit fetch words into RVC and
// 32-bit instructions, including ones that straddle two words. Optional counters: IFU_ALIGN_PERF_EN.
module ifu_inst_align #(
    parameter int unsigned       PC_LEN   = 64,
    parameter logic [PC_LEN-1:0] PC_RESET = PC_LEN'(64'h0000_0000_8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [PC_LEN-1:0] flush_pc,
    input  logic              fifo_empty,
    input  logic [31:0]       fifo_rdata,
    output logic              fifo_pop,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [PC_LEN-1:0] inst_pc,
    output logic              inst_is_rvc
`ifdef IFU_ALIGN_PERF_EN
    ,
    output logic [63:0]       perf_rvc_cnt,
    output logic [63:0]       perf_full_cnt,
    output logic [63:0]       perf_bubble_cnt
`endif
);

    localparam logic [1:0] ST_ALIGNED = 2'd0;
    localparam logic [1:0] ST_UPPER   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [15:0]       hold_q, hold_d;
    logic [PC_LEN-1:0] pc_q, pc_d;

    logic [15:0]       w_lo, w_hi;
    logic              lo_is_rvc, hi_is_rvc;
    logic              valid_raw;
    logic              bubble;
    logic              pop_raw;
    logic              fire;
    logic [PC_LEN-1:0] pc_plus2, pc_plus4;
    logic              unused_flush_pc0;

    assign w_lo      = fifo_rdata[15:0];
    assign w_hi      = fifo_rdata[31:16];
    assign lo_is_rvc = (w_lo[1:0] != 2'b11);
    assign hi_is_rvc = (w_hi[1:0] != 2'b11);
    assign pc_plus2  = pc_q + PC_LEN'(2);
    assign pc_plus4  = pc_q + PC_LEN'(4);

    // Redirect targets are always half-word aligned; the low bit carries no information.
    assign unused_flush_pc0 = flush_pc[0];

    // Presentation: what the current state shows to decode, before flush/reset gating.
    always_comb begin
        valid_raw   = 1'b0;
        bubble      = 1'b0;
        inst        = 32'h0;
        inst_is_rvc = 1'b0;
        unique case (state_q)
            ST_ALIGNED: begin
                valid_raw = ~fifo_empty;
                if (lo_is_rvc) begin
                    inst        = {16'h0, w_lo};
                    inst_is_rvc = 1'b1;
                end else begin
                    inst = fifo_rdata;
                end
            end
            ST_UPPER: begin
                if (hi_is_rvc) begin
                    valid_raw   = ~fifo_empty;
                    inst        = {16'h0, w_hi};
                    inst_is_rvc = 1'b1;
                end else begin
                    // Upper half starts a 32-bit instruction: park it and fetch the next word.
                    bubble = ~fifo_empty;
                end
            end
            ST_HOLD: begin
                valid_raw = ~fifo_empty;
                inst      = {w_lo, hold_q};
            end
            default: begin
                valid_raw = 1'b0;
            end
        endcase
    end

    assign inst_valid = valid_raw & ~flush & ~rst;
    assign fire       = inst_valid & inst_ready;
    assign inst_pc    = pc_q;

    // Next-state; flush overrides any simultaneous fire or bubble.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pc_d    = pc_q;
        pop_raw = 1'b0;
        if (flush) begin
            pc_d    = {flush_pc[PC_LEN-1:1], 1'b0};
            hold_d  = 16'h0;
            state_d = flush_pc[1] ? ST_UPPER : ST_ALIGNED;
        end else begin
            unique case (state_q)
                ST_ALIGNED: begin
                    if (fire) begin
                        if (lo_is_rvc) begin
                            pc_d    = pc_plus2;
                            state_d = ST_UPPER;
                        end else begin
                            pc_d    = pc_plus4;
                            pop_raw = 1'b1;
                        end
                    end
                end
                ST_UPPER: begin
                    if (hi_is_rvc) begin
                        if (fire) begin
                            pc_d    = pc_plus2;
                            pop_raw = 1'b1;
                            state_d = ST_ALIGNED;
                        end
                    end else if (bubble) begin
                        pop_raw = 1'b1;
                        hold_d  = w_hi;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (fire) begin
                        pc_d    = pc_plus4;
                        state_d = ST_UPPER;
                    end
                end
                default: begin
                    state_d = ST_ALIGNED;
                end
            endcase
        end
    end

    assign fifo_pop = pop_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ALIGNED;
            hold_q  <= 16'h0;
            pc_q    <= PC_RESET;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pc_q    <= pc_d;
        end
    end

`ifdef IFU_ALIGN_PERF_EN
    logic [63:0] rvc_cnt_q, rvc_cnt_d;
    logic [63:0] full_cnt_q, full_cnt_d;
    logic [63:0] bubble_cnt_q, bubble_cnt_d;

    // Counters survive flush; only reset clears them.
    always_comb begin
        rvc_cnt_d    = rvc_cnt_q + 64'(fire & inst_is_rvc);
        full_cnt_d   = full_cnt_q + 64'(fire & ~inst_is_rvc);
        bubble_cnt_d = bubble_cnt_q + 64'(fifo_empty | (bubble & ~flush));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvc_cnt_q    <= 64'h0;
            full_cnt_q   <= 64'h0;
            bubble_cnt_q <= 64'h0;
        end else begin
            rvc_cnt_q    <= rvc_cnt_d;
            full_cnt_q   <= full_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_rvc_cnt    = rvc_cnt_q;
    assign perf_full_cnt   = full_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_inst_align.sv
// Bench for ifu_inst_align: directed scenarios, then random fetch/stall/flush traffic checked
// against a half-word program-memory model of the instruction stream.
module tb_ifu_inst_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [63:0] flush_pc = 64'h0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rdata = 32'h0;
    logic        fifo_pop;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_is_rvc;
`ifdef IFU_ALIGN_PERF_EN
    logic [63:0] perf_rvc_cnt, perf_full_cnt, perf_bubble_cnt;
`endif

    ifu_inst_align dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_pop   (fifo_pop),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_is_rvc(inst_is_rvc)
`ifdef IFU_ALIGN_PERF_EN
        ,
        .perf_rvc_cnt   (perf_rvc_cnt),
        .perf_full_cnt  (perf_full_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_fired  = 0;

    logic [31:0] fq[$];
    logic [15:0] mem[256];
    logic [63:0] fetch_addr;
    logic [63:0] exp_pc;
    bit          rand_mode = 1'b0;
    bit          stalled_prev = 1'b0;

    logic        s_valid, s_pop, s_rvc, s_empty, s_flush, s_ready, s_rst;
    logic [31:0] s_inst, p_inst;
    logic [63:0] s_pc, s_fpc, p_pc;
    logic        p_rvc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_h(input logic [63:0] a);
        return mem[a[8:1]];
    endfunction

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = fifo_empty ? $urandom() : fq[0];
    endtask

    // Reference: the instruction at exp_pc is decoded straight from program memory.
    task automatic model_check();
        logic [15:0] h0;
        logic [31:0] e_inst;
        logic        e_rvc;
        check_eq("pop_when_empty", {63'h0, s_pop & s_empty}, 64'h0);
        check_eq("valid_when_empty", {63'h0, s_valid & s_empty}, 64'h0);
        if (s_flush) begin
            check_eq("flush_valid", {63'h0, s_valid}, 64'h0);
            check_eq("flush_pop", {63'h0, s_pop}, 64'h0);
            exp_pc = s_fpc & ~64'd1;
        end else begin
            if (stalled_prev) begin
                check_eq("stall_valid", {63'h0, s_valid}, 64'h1);
                check_eq("stall_inst", {32'h0, s_inst}, {32'h0, p_inst});
                check_eq("stall_pc", s_pc, p_pc);
                check_eq("stall_rvc", {63'h0, s_rvc}, {63'h0, p_rvc});
            end
            if (s_valid && s_ready) begin
                h0 = mem_h(exp_pc);
                e_rvc  = (h0[1:0] != 2'b11);
                e_inst = e_rvc ? {16'h0, h0} : {mem_h(exp_pc + 64'd2), h0};
                check_eq("rand_inst", {32'h0, s_inst}, {32'h0, e_inst});
                check_eq("rand_pc", s_pc, exp_pc);
                check_eq("rand_rvc", {63'h0, s_rvc}, {63'h0, e_rvc});
                exp_pc = exp_pc + (e_rvc ? 64'd2 : 64'd4);
                n_fired++;
            end
        end
        stalled_prev = s_valid & ~s_ready & ~s_flush;
        p_inst = s_inst;
        p_pc   = s_pc;
        p_rvc  = s_rvc;
    endtask

    task automatic sample();
        @(negedge clk);
        s_valid = inst_valid;
        s_pop   = fifo_pop;
        s_inst  = inst;
        s_pc    = inst_pc;
        s_rvc   = inst_is_rvc;
        s_empty = fifo_empty;
        s_flush = flush;
        s_ready = inst_ready;
        s_fpc   = flush_pc;
        s_rst   = rst;
        if (rand_mode) model_check();
    endtask

    // Advance one clock: apply the FIFO effect of the sampled cycle, then drive new inputs.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (s_flush || s_rst) begin
            fq.delete();
            if (s_flush) fetch_addr = s_fpc & ~64'd3;
        end else if (s_pop && fq.size() > 0) begin
            void'(fq.pop_front());
        end
        if (rand_mode) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            flush_pc   = 64'h8000_0000 + 64'($urandom_range(0, 1023));
            if (fq.size() < 4 && $urandom_range(0, 2) != 0) begin
                fq.push_back({mem_h(fetch_addr + 64'd2), mem_h(fetch_addr)});
                fetch_addr = fetch_addr + 64'd4;
            end
        end
        drive_fifo();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        inst_ready = 1'b1;
        fq.delete();
        drive_fifo();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] e_inst, input logic [63:0] e_pc,
                             input logic e_rvc, input logic e_pop);
        check_eq({tag, "_valid"}, {63'h0, s_valid}, 64'h1);
        check_eq({tag, "_inst"}, {32'h0, s_inst}, {32'h0, e_inst});
        check_eq({tag, "_pc"}, s_pc, e_pc);
        check_eq({tag, "_rvc"}, {63'h0, s_rvc}, {63'h0, e_rvc});
        check_eq({tag, "_pop"}, {63'h0, s_pop}, {63'h0, e_pop});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            r = $urandom();
            mem[i] = {r[15:2], r[16] ? 2'b11 : {1'b0, r[17]}};
        end
        fetch_addr = 64'h8000_0000;

        // Reset, then a single 32-bit instruction.
        fq.push_back(32'h0000_0013);
        drive_fifo();
        sample();
        check_eq("rst_valid", {63'h0, s_valid}, 64'h0);
        check_eq("rst_pop", {63'h0, s_pop}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample();
        check_out("t1", 32'h0000_0013, 64'h8000_0000, 1'b0, 1'b1);
        fq.push_back(32'h0000_4501);
        cycle();
        sample();
        check_out("t1_next", 32'h0000_4501, 64'h8000_0004, 1'b1, 1'b0);

        // Two RVC in one word.
        do_reset();
        fq.push_back(32'h4505_4501);
        drive_fifo();
        sample();
        check_out("t2a", 32'h0000_4501, 64'h8000_0000, 1'b1, 1'b0);
        cycle();
        sample();
        check_out("t2b", 32'h0000_4505, 64'h8000_0002, 1'b1, 1'b1);

        // Straddling 32-bit instruction.
        do_reset();
        fq.push_back(32'h0013_4501);
        fq.push_back(32'h0000_0000);
        drive_fifo();
        sample();
        check_out("t3a", 32'h0000_4501, 64'h8000_0000, 1'b1, 1'b0);
        cycle();
        sample();
        check_eq("t3_bubble_valid", {63'h0, s_valid}, 64'h0);
        check_eq("t3_bubble_pop", {63'h0, s_pop}, 64'h1);
        cycle();
        sample();
        check_out("t3c", 32'h0000_0013, 64'h8000_0002, 1'b0, 1'b0);
        cycle();
        sample();
        check_out("t3d", 32'h0000_0000, 64'h8000_0006, 1'b1, 1'b1);

        // HOLD with the FIFO empty for three cycles.
        do_reset();
        fq.push_back(32'h0013_4501);
        drive_fifo();
        sample();
        cycle();
        sample();
        check_eq("t4_bubble_pop", {63'h0, s_pop}, 64'h1);
        cycle();
        repeat (3) begin
            sample();
            check_eq("t4_empty_valid", {63'h0, s_valid}, 64'h0);
            check_eq("t4_empty_pop", {63'h0, s_pop}, 64'h0);
            cycle();
        end
        fq.push_back(32'h0000_0000);
        drive_fifo();
        sample();
        check_out("t4_resume", 32'h0000_0013, 64'h8000_0002, 1'b0, 1'b0);

        // Stall, then flush coinciding with ready.
        do_reset();
        inst_ready = 1'b0;
        fq.push_back(32'h0000_4501);
        drive_fifo();
        sample();
        check_out("t5_stall1", 32'h0000_4501, 64'h8000_0000, 1'b1, 1'b0);
        cycle();
        sample();
        check_out("t5_stall2", 32'h0000_4501, 64'h8000_0000, 1'b1, 1'b0);
        cycle();
        flush      = 1'b1;
        flush_pc   = 64'h8000_1002;
        inst_ready = 1'b1;
        sample();
        check_eq("t5_flush_valid", {63'h0, s_valid}, 64'h0);
        check_eq("t5_flush_pop", {63'h0, s_pop}, 64'h0);
        cycle();
        flush = 1'b0;
        fq.push_back(32'h4511_0013);
        drive_fifo();
        sample();
        check_out("t5_redirect", 32'h0000_4511, 64'h8000_1002, 1'b1, 1'b1);

        // Reset while a straddling instruction is half-assembled.
        do_reset();
        fq.push_back(32'h0013_4501);
        fq.push_back(32'h0000_0000);
        drive_fifo();
        sample();
        cycle();
        sample();
        cycle();
        sample();
        check_eq("t6_hold_valid", {63'h0, s_valid}, 64'h1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", {63'h0, inst_valid}, 64'h0);
        check_eq("t6_rst_pop", {63'h0, fifo_pop}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fq.delete();
        fq.push_back(32'h0000_0013);
        drive_fifo();
        sample();
        check_out("t6_after", 32'h0000_0013, 64'h8000_0000, 1'b0, 1'b1);

        // PC wrap; flush_pc bit0 ignored.
        do_reset();
        flush    = 1'b1;
        flush_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        sample();
        cycle();
        flush = 1'b0;
        fq.push_back(32'h4501_0000);
        drive_fifo();
        sample();
        check_out("t7_top", 32'h0000_4501, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
        fq.push_back(32'h0000_0013);
        cycle();
        sample();
        check_out("t7_wrap", 32'h0000_0013, 64'h0, 1'b0, 1'b1);

        // Random traffic against the memory model.
        do_reset();
        fetch_addr   = 64'h8000_0000;
        exp_pc       = 64'h8000_0000;
        stalled_prev = 1'b0;
        rand_mode    = 1'b1;
        drive_fifo();
        repeat (3000) begin
            sample();
            cycle();
        end
        rand_mode = 1'b0;
        check_eq("rand_progress", {63'h0, n_fired > 500}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
